// File: rtl/manual_step_pkg.sv
// Shared encodings for the manual single-step controller: per-channel mode
// selects and the press FSM state type.
package manual_step_pkg;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FIRE = 2'b01,
        HOLD = 2'b10
    } press_state_t;

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: 2-flop synchroniser followed by a debouncer that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_clean
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_clean;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_clean <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_clean) begin
                r_cnt <= '0;
            // r_cnt counts earlier differing samples, so this is the Nth one
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_clean <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clean = r_clean;

endmodule

// File: rtl/manual_step_ctrl.sv
// Multi-channel manual step controller: debounced buttons -> press events ->
// toggle level, single step pulse or N-cycle step burst. Optional auto-repeat
// while a button is held is enabled by defining MANUAL_STEP_AUTOREPEAT_EN.
//
//   state | meaning
//   IDLE  | button released, waiting for a debounced press
//   FIRE  | one-cycle press event (o_event high)
//   HOLD  | button still held, waiting for release (or next repeat)
module manual_step_ctrl
    import manual_step_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BURST_W         = 8,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [CHANNELS-1:0]     i_button,
    input  logic [2*CHANNELS-1:0]   i_mode,
    input  logic [BURST_W-1:0]      i_burst_len,
    output logic [CHANNELS-1:0]     o_level,
    output logic [CHANNELS-1:0]     o_step,
    output logic [CHANNELS-1:0]     o_event,
    output logic [CHANNELS-1:0]     o_busy
);

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("manual_step_ctrl: illegal parameter value");
    end

`ifdef MANUAL_STEP_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic               w_clean;
        logic [1:0]         w_mode;
        press_state_t       r_state;
        logic               r_event;
        logic               r_level;
        logic               r_step;
        logic               r_busy;
        logic [BURST_W-1:0] r_burst_cnt;
`ifdef MANUAL_STEP_AUTOREPEAT_EN
        logic [REP_W-1:0]   r_rep_cnt;
`endif

        assign w_mode = i_mode[2*g +: 2];

        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_raw   (i_button[g]),
            .o_clean (w_clean)
        );

        // r_event is registered alongside the FIRE transition so it equals (state==FIRE)
        always_ff @(posedge i_clock) begin
            if (!i_reset) begin
                r_state   <= IDLE;
                r_event   <= 1'b0;
`ifdef MANUAL_STEP_AUTOREPEAT_EN
                r_rep_cnt <= '0;
`endif
            end else begin
                r_event <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (w_clean) begin
                            r_state   <= FIRE;
                            r_event   <= 1'b1;
`ifdef MANUAL_STEP_AUTOREPEAT_EN
                            r_rep_cnt <= REP_W'(REPEAT_DELAY - 2);
`endif
                        end
                    end
                    FIRE: r_state <= HOLD;
                    HOLD: begin
                        if (!w_clean) begin
                            r_state   <= IDLE;
`ifdef MANUAL_STEP_AUTOREPEAT_EN
                            r_rep_cnt <= '0;
                        end else if (r_rep_cnt == '0) begin
                            r_state   <= FIRE;
                            r_event   <= 1'b1;
                            r_rep_cnt <= REP_W'(REPEAT_PERIOD - 2);
                        end else begin
                            r_rep_cnt <= r_rep_cnt - 1'b1;
`endif
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end

        // While a burst runs, events are dropped and the mode is not looked at
        always_ff @(posedge i_clock) begin
            if (!i_reset) begin
                r_level     <= 1'b0;
                r_step      <= 1'b0;
                r_busy      <= 1'b0;
                r_burst_cnt <= '0;
            end else if (r_busy) begin
                if (r_burst_cnt == BURST_W'(1)) begin
                    r_busy      <= 1'b0;
                    r_step      <= 1'b0;
                    r_burst_cnt <= '0;
                end else begin
                    r_burst_cnt <= r_burst_cnt - 1'b1;
                end
            end else begin
                r_step <= 1'b0;
                if (r_event) begin
                    case (w_mode)
                        MODE_TOGGLE: r_level <= ~r_level;
                        MODE_PULSE:  r_step  <= 1'b1;
                        MODE_BURST: begin
                            if (i_burst_len != '0) begin
                                r_busy      <= 1'b1;
                                r_step      <= 1'b1;
                                r_burst_cnt <= i_burst_len;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign o_level[g] = r_level;
        assign o_step[g]  = r_step;
        assign o_event[g] = r_event;
        assign o_busy[g]  = r_busy;
    end

endmodule

// File: tb/tb_manual_step_ctrl.sv
// Scoreboard bench for manual_step_ctrl (2 channels, debounce 4): directed
// scenarios plus random presses, predicted by a time-stamped event model.
module tb_manual_step_ctrl;

    localparam int CH = 2;
    localparam int DB = 4;

    typedef struct {
        int t;
        int v;
    } rec_t;

    logic           clk = 1'b0;
    logic           i_reset;
    logic [CH-1:0]  i_button;
    logic [2*CH-1:0] i_mode;
    logic [7:0]     i_burst_len;
    logic [CH-1:0]  o_level, o_step, o_event, o_busy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    int   ev_q   [CH][$];
    rec_t step_q [CH][$];
    rec_t busy_q [CH][$];
    rec_t lvl_q  [CH][$];
    int   busy_end [CH];
    logic mlvl [CH];

    manual_step_ctrl #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .BURST_W         (8),
        .REPEAT_DELAY    (1000),
        .REPEAT_PERIOD   (250)
    ) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_button    (i_button),
        .i_mode      (i_mode),
        .i_burst_len (i_burst_len),
        .o_level     (o_level),
        .o_step      (o_step),
        .o_event     (o_event),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic report(input string name, input int c, input int gt, input int gv,
                          input int et, input int ev);
        failures++;
        $display("FAIL %s ch%0d: got t=%0d v=%0d, expected t=%0d v=%0d", name, c, gt, gv, et, ev);
    endtask

    // ---------------- monitor ----------------
    logic prev_step [CH];
    logic prev_busy [CH];
    logic prev_lvl  [CH];
    int   step_start [CH];
    int   busy_start [CH];
    rec_t mr;
    int   mt;

    initial begin
        for (int c = 0; c < CH; c++) begin
            prev_step[c] = 1'b0; prev_busy[c] = 1'b0; prev_lvl[c] = 1'b0;
            step_start[c] = 0;   busy_start[c] = 0;
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (o_event[c]) begin
                checks++;
                if (ev_q[c].size() == 0) report("event_unexpected", c, cyc, 1, -1, 0);
                else begin
                    mt = ev_q[c].pop_front();
                    if (mt != cyc) report("event_time", c, cyc, 1, mt, 1);
                end
            end
            if (o_step[c] && !prev_step[c]) step_start[c] = cyc;
            if (!o_step[c] && prev_step[c]) begin
                checks++;
                if (step_q[c].size() == 0) report("step_unexpected", c, step_start[c], cyc - step_start[c], -1, 0);
                else begin
                    mr = step_q[c].pop_front();
                    if (mr.t != step_start[c] || mr.v != cyc - step_start[c])
                        report("step_run", c, step_start[c], cyc - step_start[c], mr.t, mr.v);
                end
            end
            if (o_busy[c] && !prev_busy[c]) busy_start[c] = cyc;
            if (!o_busy[c] && prev_busy[c]) begin
                checks++;
                if (busy_q[c].size() == 0) report("busy_unexpected", c, busy_start[c], cyc - busy_start[c], -1, 0);
                else begin
                    mr = busy_q[c].pop_front();
                    if (mr.t != busy_start[c] || mr.v != cyc - busy_start[c])
                        report("busy_run", c, busy_start[c], cyc - busy_start[c], mr.t, mr.v);
                end
            end
            if (o_level[c] != prev_lvl[c]) begin
                checks++;
                if (lvl_q[c].size() == 0) report("level_unexpected", c, cyc, int'(o_level[c]), -1, 0);
                else begin
                    mr = lvl_q[c].pop_front();
                    if (mr.t != cyc || mr.v != int'(o_level[c]))
                        report("level_change", c, cyc, int'(o_level[c]), mr.t, mr.v);
                end
            end
            prev_step[c] = o_step[c];
            prev_busy[c] = o_busy[c];
            prev_lvl[c]  = o_level[c];
        end
    end

    // ---------------- reference model ----------------
    // A press event at cycle e acts on the mode/burst length present at e,
    // unless the channel is still inside a burst (busy through busy_end).
    task automatic model_event(input int c, input int e);
        logic [1:0] m;
        int         nlen;
        rec_t       r;
        m    = i_mode[2*c +: 2];
        nlen = int'(i_burst_len);
        ev_q[c].push_back(e);
        if (e <= busy_end[c]) return;
        case (m)
            2'b00: begin
                mlvl[c] = ~mlvl[c];
                r.t = e + 1; r.v = int'(mlvl[c]);
                lvl_q[c].push_back(r);
            end
            2'b01: begin
                r.t = e + 1; r.v = 1;
                step_q[c].push_back(r);
            end
            2'b10: begin
                if (nlen > 0) begin
                    r.t = e + 1; r.v = nlen;
                    step_q[c].push_back(r);
                    busy_q[c].push_back(r);
                    busy_end[c] = e + nlen;
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Raw press of h cycles; the event lands DB+3 edges after the drive point.
    task automatic press(input logic [1:0] mask, input int h, input int gap);
        int n;
        n = cyc;
        i_button = mask;
        if (h >= DB)
            for (int c = 0; c < CH; c++)
                if (mask[c]) model_event(c, n + DB + 3);
        tick(h);
        i_button = '0;
        tick(gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   n, e;
        rec_t r;
        logic [1:0] mask;
        int   h, gap;

        for (int c = 0; c < CH; c++) begin
            busy_end[c] = -1;
            mlvl[c]     = 1'b0;
        end
        i_reset = 1'b0; i_button = '0; i_mode = '0; i_burst_len = '0;
        tick(3);
        checks++; if (o_level != '0) report("reset_level", 0, int'(o_level), 0, 0, 0);
        checks++; if (o_step  != '0) report("reset_step",  0, int'(o_step),  0, 0, 0);
        checks++; if (o_event != '0) report("reset_event", 0, int'(o_event), 0, 0, 0);
        checks++; if (o_busy  != '0) report("reset_busy",  0, int'(o_busy),  0, 0, 0);
        i_reset = 1'b1;
        tick(5);

        // glitch rejection, then a long pulse-mode hold and a re-press
        i_mode = 4'b0001;
        press(2'b01, 3, 12);
        press(2'b01, 50, 12);
        press(2'b01, 6, 12);

        // toggle on ch1, three presses
        i_mode = 4'b0001;
        for (int k = 0; k < 3; k++) press(2'b10, 6, 12);
        checks++;
        if (o_level[1] != mlvl[1]) report("toggle_final", 1, int'(o_level[1]), 0, 0, int'(mlvl[1]));

        // burst 5, burst_len changed mid-burst, re-press during the burst
        i_mode = 4'b0010; i_burst_len = 8'd5;
        press(2'b01, 4, 5);
        i_burst_len = 8'd2;
        press(2'b01, 4, 20);
        // long burst: second event lands inside it and must be ignored
        i_burst_len = 8'd20;
        press(2'b01, 4, 5);
        press(2'b01, 4, 30);
        // burst length zero
        i_burst_len = 8'd0;
        press(2'b01, 5, 15);

        // reset at burst cycle 10
        i_mode = 4'b0010; i_burst_len = 8'd200;
        n = cyc; e = n + DB + 3;
        i_button = 2'b01;
        ev_q[0].push_back(e);
        r.t = e + 1; r.v = 10;
        step_q[0].push_back(r);
        busy_q[0].push_back(r);
        tick(4);
        i_button = '0;
        tick(e + 10 - cyc);
        i_reset = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (mlvl[c]) begin
                r.t = e + 11; r.v = 0;
                lvl_q[c].push_back(r);
            end
            mlvl[c] = 1'b0;
            busy_end[c] = -1;
        end
        tick(1);
        checks++; if (o_step  != '0) report("midburst_reset_step",  0, int'(o_step),  0, 0, 0);
        checks++; if (o_busy  != '0) report("midburst_reset_busy",  0, int'(o_busy),  0, 0, 0);
        checks++; if (o_level != '0) report("midburst_reset_level", 0, int'(o_level), 0, 0, 0);
        tick(1);
        i_reset = 1'b1;
        tick(10);
        i_mode = 4'b0001;
        press(2'b01, 5, 12);

        // simultaneous presses, ch1 disabled
        i_mode = 4'b1101;
        press(2'b11, 6, 12);

        // random presses across modes, burst lengths and hold times
        for (int k = 0; k < 40; k++) begin
            mask        = 2'($urandom_range(1, 3));
            i_mode      = 4'($urandom());
            i_burst_len = 8'($urandom_range(0, 30));
            h   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DB - 1) : $urandom_range(DB, DB + 20);
            gap = $urandom_range(DB + 6, DB + 30);
            press(mask, h, gap);
        end

        tick(60);
        for (int c = 0; c < CH; c++) begin
            checks++; if (ev_q[c].size()   != 0) report("missing_event", c, 0, 0, ev_q[c].size(), 0);
            checks++; if (step_q[c].size() != 0) report("missing_step",  c, 0, 0, step_q[c].size(), 0);
            checks++; if (busy_q[c].size() != 0) report("missing_busy",  c, 0, 0, busy_q[c].size(), 0);
            checks++; if (lvl_q[c].size()  != 0) report("missing_level", c, 0, 0, lvl_q[c].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/manual_step_ctrl.md
Name: manual_step_ctrl

Overview:
- Parametrised, multi-channel successor to the single-button manual clock used for board-level single-stepping of the pipeline.
- Each channel synchronises and debounces one push-button, then turns each press into a step event.
- Per channel, a step event drives one of three outputs: a toggled level, a single-cycle step pulse, or a burst of N consecutive step-enable cycles.
- Outputs feed CPU clock-enable / step logic and board LEDs.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before the debounced state changes (>=2). Counter width is clog2(DEBOUNCE_CYCLES).
- BURST_W, 8, width of the burst length input.
- REPEAT_DELAY, 1000, auto-repeat hold delay in cycles. Used only with the optional feature.
- REPEAT_PERIOD, 250, auto-repeat period in cycles. Used only with the optional feature.

Ports:
- clock, in, 1, single system clock. All logic on the rising edge.
- reset, in, 1, synchronous, active-low reset. Sampled on the clock rising edge; 0 = reset.
- button, in, CHANNELS, raw asynchronous push-buttons, active-high.
- mode, in, 2*CHANNELS, per-channel mode. Bits [2i+1:2i] belong to channel i. 00 toggle, 01 pulse, 10 burst, 11 disabled.
- burst_len, in, BURST_W, burst length shared by all channels.
- level, out, CHANNELS, toggle-mode output per channel.
- step, out, CHANNELS, step-enable output per channel (pulse and burst modes).
- event, out, CHANNELS, one-cycle press event per channel (debug).
- busy, out, CHANNELS, high while a burst is in progress on that channel.

Behaviour:
- Reset (reset==0 at a rising edge):
  - level, step, event, busy = 0.
  - Synchroniser flops, debounced state and counters = 0.
  - FSM = IDLE, burst counters = 0.
  - Reset mid-burst aborts the burst immediately; step=0 on the next cycle.
- Synchroniser: 2-flop per button bit.
- Debounce:
  - If the synchronised value equals the debounced state, the counter clears.
  - Otherwise the counter increments. On the edge where it has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced state takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the debounced state.
- Press FSM per channel:
  - IDLE -> FIRE when debounced==1.
  - FIRE -> HOLD unconditionally (one cycle).
  - HOLD -> IDLE when debounced==0. Otherwise stay in HOLD.
  - event = (state==FIRE). Exactly one event per press, no matter how long the button is held.
  - Latency from the first stable synchronised high to event is DEBOUNCE_CYCLES+1 cycles.
- Mode is sampled in the cycle event is high.
  - Toggle (00): level[i] inverts on the edge after event. step is unaffected.
  - Pulse (01): step[i]=1 for exactly the one cycle after event.
  - Burst (10):
    - On event with burst_len==N>0: busy=1 and step=1 for exactly N consecutive cycles, starting the cycle after event. busy falls in the same cycle step falls.
    - N==0: no step and busy stays 0.
    - burst_len is latched at event, so later changes do not alter a running burst.
  - Disabled (11): events are still flagged on event, but no output reacts.
- Events arriving while busy[i]==1 are ignored in every mode. The mode is locked until the burst ends.
- A mode change with no event pending has no effect on level; level holds its value.
- Channels are fully independent. Simultaneous presses are all serviced in the same cycles.

Optional Feature:
- Macro: MANUAL_STEP_AUTOREPEAT_EN.
- Defined:
  - In HOLD, a per-channel counter counts held cycles.
  - The first repeat event fires when the count reaches REPEAT_DELAY. Further repeat events fire every REPEAT_PERIOD cycles while the button stays held.
  - Repeat events behave exactly like FIRE events, including the busy-ignore rule.
  - Releasing the button clears the counter.
- Undefined: no repeat counters exist, and there is exactly one event per press.

Decomposition:
- Package manual_step_pkg holds:
  - mode encodings MODE_TOGGLE=2'b00, MODE_PULSE=2'b01, MODE_BURST=2'b10, MODE_OFF=2'b11;
  - FSM state encodings IDLE, FIRE, HOLD (2-bit).
- Sub-module button_debounce: one channel's synchroniser plus debounce counter, with parameter DEBOUNCE_CYCLES.
  - Ports: clock, reset, raw, clean.
  - Instantiated CHANNELS times via generate.
- The press FSM and mode logic stay in the top module, also generated per channel.

Test Plan (DEBOUNCE_CYCLES=4, CHANNELS=2, BURST_W=8):
- Glitch rejection: ch0 mode 01, button high for 3 cycles then low -> no event, step stays 0.
- Pulse: ch0 mode 01, button held high for 50 cycles -> exactly one event, then step=1 for one cycle. No further steps until the button is released and pressed again.
- Toggle: ch1 mode 00, three clean presses -> level[1] goes 0->1->0->1, with one change per press.
- Burst: ch0 mode 10, burst_len=5, one press -> busy high and step high for exactly 5 consecutive cycles. A second press during the burst is ignored. Changing burst_len to 2 mid-burst has no effect.
- Reset mid-burst: burst_len=200, drive reset=0 at burst cycle 10 -> next cycle step=0, busy=0, level=0. After release, a new press works normally.
- Simultaneous and disabled: both buttons pressed in the same cycle with ch0 mode 01 and ch1 mode 11 -> event=2'b11 in the same cycle, step[0] pulses, step[1] and level[1] stay 0.
